// File: rtl/ebr_ram_pkg.sv
// ebr_ram_pkg: shared types and elaboration helpers for the ebr_ram_mw block RAM.
//   state_e     : clear-sequencer state {ST_CLEAR, ST_READY}
//   max_w       : wider of the two port widths (array word width)
//   lane_bits   : log2 of array-word / port-word ratio
//   lane_sel_w  : storage width for a lane index (never zero)
//   addr_w      : port address width in port-word units
//   width_ok    : legal port width check against LEGAL_WIDTHS
package ebr_ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Bit n set means a port width of n bits is supported (2, 4, 8, 16, 32).
    localparam logic [63:0] LEGAL_WIDTHS = 64'h0000_0001_0001_0114;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned lane_bits(input int unsigned dw_max, input int unsigned dw);
        return $clog2(dw_max / dw);
    endfunction

    function automatic int unsigned lane_sel_w(input int unsigned dw_max, input int unsigned dw);
        return (lane_bits(dw_max, dw) == 0) ? 1 : lane_bits(dw_max, dw);
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth_bits,
                                           input int unsigned dw_max,
                                           input int unsigned dw);
        return depth_bits + lane_bits(dw_max, dw);
    endfunction

    function automatic bit width_ok(input int unsigned dw);
        return (dw < 64) && LEGAL_WIDTHS[dw[5:0]];
    endfunction

endpackage

// File: rtl/ebr_ram_lane_mux.sv
// ebr_ram_lane_mux: lane handling for one port of ebr_ram_mw.
//   Write side: places i_data into lane i_lane of i_word, honouring i_mask
//   (1 = keep old bit), result on o_merged_c.
//   Read side: registers i_lane when i_lane_en, then selects that lane of
//   i_word onto o_lane_c.
// Ports:
//   clk, resetn  : clock, async active-low reset
//   i_lane_en    : capture i_lane into the read-lane register
//   i_lane       : lane index within the array word
//   i_word       : array word (old word for writes, read word for reads)
//   i_data       : port-width write data
//   i_mask       : port-width write mask, 1 = bit keeps old value
//   o_merged_c   : array word with the masked lane update applied
//   o_lane_c     : lane of i_word selected by the registered lane
module ebr_ram_lane_mux
    import ebr_ram_pkg::*;
#(
    parameter int unsigned DW_MAX = 16,
    parameter int unsigned DW     = 16
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                i_lane_en,
    input  logic [lane_sel_w(DW_MAX, DW)-1:0]   i_lane,
    input  logic [DW_MAX-1:0]                   i_word,
    input  logic [DW-1:0]                       i_data,
    input  logic [DW-1:0]                       i_mask,
    output logic [DW_MAX-1:0]                   o_merged_c,
    output logic [DW-1:0]                       o_lane_c
);

    localparam int unsigned LSW = lane_sel_w(DW_MAX, DW);

    logic [LSW-1:0]    r_lane;
    logic [31:0]       w_shift_wr;
    logic [31:0]       w_shift_rd;
    logic [DW_MAX-1:0] w_data_x;
    logic [DW_MAX-1:0] w_keep_x;

    // Lane index captured alongside the array read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lane <= '0;
        end else if (i_lane_en) begin
            r_lane <= i_lane;
        end
    end

    assign w_shift_wr = 32'(i_lane) * DW;
    assign w_shift_rd = 32'(r_lane) * DW;

    // Outside the addressed lane every bit is kept.
    assign w_data_x   = DW_MAX'(i_data) << w_shift_wr;
    assign w_keep_x   = ~(DW_MAX'(~i_mask) << w_shift_wr);
    assign o_merged_c = (i_word & w_keep_x) | (w_data_x & ~w_keep_x);

    assign o_lane_c   = DW'(i_word >> w_shift_rd);

endmodule

// File: rtl/ebr_ram_mw.sv
// ebr_ram_mw: simple-dual-port block RAM with independent write/read widths,
// per-bit write mask, write-first collision bypass and a self-clearing
// sequencer that fills the array with CLEAR_VAL after reset or on request.
// Optional macro EBR_RAM_OUTREG_EN adds an output register stage (read
// latency 2 instead of 1); busy/clear timing is the same in both builds.
// Ports:
//   clk        : clock, rising edge
//   resetn     : async active-low reset, restarts the clear sequencer
//   clear_req  : one-cycle pulse, refill array with CLEAR_VAL
//   busy       : clear sequencer running, port accesses ignored
//   we/waddr/wdata/wmask : write port (address in DW_W units, mask 1 = keep)
//   re/raddr   : read port (address in DW_R units)
//   rdata      : read data, holds last value when no read
//   rvalid     : rdata carries the result of a read
module ebr_ram_mw
    import ebr_ram_pkg::*;
#(
    parameter int unsigned DW_W       = 16,
    parameter int unsigned DW_R       = 16,
    parameter int unsigned DEPTH_BITS = 8,
    parameter logic [max_w(DW_W, DW_R)-1:0] CLEAR_VAL = '0
) (
    input  logic                                                clk,
    input  logic                                                resetn,
    input  logic                                                clear_req,
    output logic                                                busy,
    input  logic                                                we,
    input  logic [addr_w(DEPTH_BITS, max_w(DW_W, DW_R), DW_W)-1:0] waddr,
    input  logic [DW_W-1:0]                                     wdata,
    input  logic [DW_W-1:0]                                     wmask,
    input  logic                                                re,
    input  logic [addr_w(DEPTH_BITS, max_w(DW_W, DW_R), DW_R)-1:0] raddr,
    output logic [DW_R-1:0]                                     rdata,
    output logic                                                rvalid
);

    localparam int unsigned DW_MAX = max_w(DW_W, DW_R);
    localparam int unsigned LB_W   = lane_bits(DW_MAX, DW_W);
    localparam int unsigned LB_R   = lane_bits(DW_MAX, DW_R);
    localparam int unsigned LSW_W  = lane_sel_w(DW_MAX, DW_W);
    localparam int unsigned LSW_R  = lane_sel_w(DW_MAX, DW_R);
    localparam int unsigned DEPTH  = 32'd1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS-1:0] CLR_LAST = '1;

    if (!width_ok(DW_W) || !width_ok(DW_R)) begin : g_bad_width
        $error("ebr_ram_mw: DW_W and DW_R must each be 2, 4, 8, 16 or 32");
    end

    logic [DW_MAX-1:0]     r_mem [DEPTH];

    state_e                r_state;
    state_e                w_state_nxt;
    logic [DEPTH_BITS-1:0] r_clr_addr;
    logic [DEPTH_BITS-1:0] w_clr_addr_nxt;
    logic                  r_busy;

    logic                  w_port_en;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic [DEPTH_BITS-1:0] w_wword;
    logic [DEPTH_BITS-1:0] w_rword;
    logic [LSW_W-1:0]      w_wlane;
    logic [LSW_R-1:0]      w_rlane;
    logic                  w_collide;
    logic [DW_MAX-1:0]     w_wold;
    logic [DW_MAX-1:0]     w_wmerged;
    logic [DW_MAX-1:0]     r_rword_q;
    logic                  r_rvalid;
    logic [DW_R-1:0]       w_rdata_c;
    logic [DW_MAX-1:0]     w_unused_rd_merged;
    logic [DW_W-1:0]       w_unused_wr_lane;

    // Clear sequencer: state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_busy     <= (w_state_nxt == ST_CLEAR);
        end
    end

    // Clear sequencer: next state. Last word written, then READY.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + DEPTH_BITS'(1);
                if (r_clr_addr == CLR_LAST) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    assign busy = r_busy;

    // Port accesses coinciding with a clear request are dropped.
    assign w_port_en = (r_state == ST_READY) && !clear_req;
    assign w_wr_fire = w_port_en && we;
    assign w_rd_fire = w_port_en && re;

    assign w_wword = DEPTH_BITS'(waddr >> LB_W);
    assign w_rword = DEPTH_BITS'(raddr >> LB_R);
    assign w_wlane = LSW_W'(waddr) & LSW_W'((32'd1 << LB_W) - 32'd1);
    assign w_rlane = LSW_R'(raddr) & LSW_R'((32'd1 << LB_R) - 32'd1);

    assign w_collide = w_wr_fire && w_rd_fire && (w_wword == w_rword);
    assign w_wold    = r_mem[w_wword];

    // Write lane placement and bit-mask merge.
    ebr_ram_lane_mux #(
        .DW_MAX (DW_MAX),
        .DW     (DW_W)
    ) u_wr_mux (
        .clk        (clk),
        .resetn     (resetn),
        .i_lane_en  (1'b0),
        .i_lane     (w_wlane),
        .i_word     (w_wold),
        .i_data     (wdata),
        .i_mask     (wmask),
        .o_merged_c (w_wmerged),
        .o_lane_c   (w_unused_wr_lane)
    );

    // Array write: sequencer owns the array while clearing.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= CLEAR_VAL;
        end else if (w_wr_fire) begin
            r_mem[w_wword] <= w_wmerged;
        end
    end

    // Array read; same-word write in the same cycle bypasses the merged word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rword_q <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rvalid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rword_q <= w_collide ? w_wmerged : r_mem[w_rword];
            end
        end
    end

    // Read lane select, lane index registered with the word.
    ebr_ram_lane_mux #(
        .DW_MAX (DW_MAX),
        .DW     (DW_R)
    ) u_rd_mux (
        .clk        (clk),
        .resetn     (resetn),
        .i_lane_en  (w_rd_fire),
        .i_lane     (w_rlane),
        .i_word     (r_rword_q),
        .i_data     ('0),
        .i_mask     ('1),
        .o_merged_c (w_unused_rd_merged),
        .o_lane_c   (w_rdata_c)
    );

`ifdef EBR_RAM_OUTREG_EN
    logic [DW_R-1:0] r_rdata_q;
    logic            r_rvalid_q;

    // Extra output stage; data only advances on a valid read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata_q  <= '0;
            r_rvalid_q <= 1'b0;
        end else begin
            r_rvalid_q <= r_rvalid;
            if (r_rvalid) begin
                r_rdata_q <= w_rdata_c;
            end
        end
    end

    assign rdata  = r_rdata_q;
    assign rvalid = r_rvalid_q;
`else
    assign rdata  = w_rdata_c;
    assign rvalid = r_rvalid;
`endif

endmodule

// File: tb/tb_ebr_ram_mw.sv
// tb_ebr_ram_mw: directed bench for ebr_ram_mw with an array-level reference
// model. Instance A is 16/16 bits x 256 words, instance B is 16-bit write /
// 4-bit read x 16 words with a non-zero fill pattern.
module tb_ebr_ram_mw;

`ifdef EBR_RAM_OUTREG_EN
    localparam bit OUTREG = 1'b1;
`else
    localparam bit OUTREG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        a_clear_req, a_we, a_re, a_busy, a_rvalid;
    logic [7:0]  a_waddr, a_raddr;
    logic [15:0] a_wdata, a_wmask, a_rdata;

    logic        b_clear_req, b_we, b_re, b_busy, b_rvalid;
    logic [3:0]  b_waddr;
    logic [5:0]  b_raddr;
    logic [15:0] b_wdata, b_wmask;
    logic [3:0]  b_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ebr_ram_mw #(.DW_W(16), .DW_R(16), .DEPTH_BITS(8), .CLEAR_VAL(16'h0000)) u_dut_a (
        .clk(clk), .resetn(resetn), .clear_req(a_clear_req), .busy(a_busy),
        .we(a_we), .waddr(a_waddr), .wdata(a_wdata), .wmask(a_wmask),
        .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid)
    );

    ebr_ram_mw #(.DW_W(16), .DW_R(4), .DEPTH_BITS(4), .CLEAR_VAL(16'h5A5A)) u_dut_b (
        .clk(clk), .resetn(resetn), .clear_req(b_clear_req), .busy(b_busy),
        .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .wmask(b_wmask),
        .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (index 0 = A, 1 = B) ----------------
    logic [15:0] m_mem [2][256];
    bit          m_busy [2];
    int          m_cnt  [2];
    bit          m_v1 [2];
    bit          m_v2 [2];
    logic [15:0] m_d1 [2];
    logic [15:0] m_d2 [2];

    task automatic model_step(input int k, input logic cr, input logic we, input int wa,
                              input logic [15:0] wd, input logic [15:0] wm,
                              input logic re, input int ra);
        int          depth, ratio, rdw, word, lane;
        logic [15:0] clrv, fd;
        bit          fv;
        depth = (k == 0) ? 256 : 16;
        ratio = (k == 0) ? 1 : 4;
        rdw   = (k == 0) ? 16 : 4;
        clrv  = (k == 0) ? 16'h0000 : 16'h5A5A;
        fv = 1'b0;
        fd = '0;
        if (m_busy[k]) begin
            m_mem[k][m_cnt[k]] = clrv;
            if (m_cnt[k] == depth - 1) m_busy[k] = 1'b0;
            m_cnt[k]++;
        end else if (cr) begin
            m_busy[k] = 1'b1;
            m_cnt[k]  = 0;
        end else begin
            if (we) m_mem[k][wa] = (m_mem[k][wa] & wm) | (wd & ~wm);
            if (re) begin
                word = ra / ratio;
                lane = ra % ratio;
                fd   = (m_mem[k][word] >> (lane * rdw)) & 16'((32'd1 << rdw) - 1);
                fv   = 1'b1;
            end
        end
        m_v2[k] = m_v1[k];
        if (m_v1[k]) m_d2[k] = m_d1[k];
        m_v1[k] = fv;
        if (fv) m_d1[k] = fd;
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b1; m_cnt[k] = 0;
                m_v1[k] = 1'b0; m_v2[k] = 1'b0; m_d1[k] = '0; m_d2[k] = '0;
            end
        end else begin
            model_step(0, a_clear_req, a_we, int'(a_waddr), a_wdata, a_wmask, a_re, int'(a_raddr));
            model_step(1, b_clear_req, b_we, int'(b_waddr), b_wdata, b_wmask, b_re, int'(b_raddr));
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        #1;
        chk("a_busy",   32'(a_busy),   32'(m_busy[0]));
        chk("a_rvalid", 32'(a_rvalid), 32'(OUTREG ? m_v2[0] : m_v1[0]));
        chk("a_rdata",  32'(a_rdata),  32'(OUTREG ? m_d2[0] : m_d1[0]));
        chk("b_busy",   32'(b_busy),   32'(m_busy[1]));
        chk("b_rvalid", 32'(b_rvalid), 32'(OUTREG ? m_v2[1] : m_v1[1]));
        chk("b_rdata",  32'(b_rdata),  32'(OUTREG ? m_d2[1][3:0] : m_d1[1][3:0]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic a_idle();
        a_clear_req = 0; a_we = 0; a_re = 0; a_waddr = 0; a_raddr = 0; a_wdata = 0; a_wmask = 0;
    endtask

    task automatic a_write(input logic [7:0] adr, input logic [15:0] d, input logic [15:0] m);
        a_we = 1; a_waddr = adr; a_wdata = d; a_wmask = m;
        @(negedge clk);
        a_idle();
    endtask

    task automatic a_read(input logic [7:0] adr, output logic [15:0] d, output logic v);
        a_re = 1; a_raddr = adr;
        @(negedge clk);
        a_idle();
        if (OUTREG) @(negedge clk);
        d = a_rdata; v = a_rvalid;
    endtask

    task automatic a_wr_rd(input logic [7:0] wa, input logic [15:0] wd, input logic [15:0] wm,
                           input logic [7:0] ra, output logic [15:0] d);
        a_we = 1; a_waddr = wa; a_wdata = wd; a_wmask = wm; a_re = 1; a_raddr = ra;
        @(negedge clk);
        a_idle();
        if (OUTREG) @(negedge clk);
        d = a_rdata;
    endtask

    task automatic b_write(input logic [3:0] adr, input logic [15:0] d);
        b_we = 1; b_waddr = adr; b_wdata = d; b_wmask = 16'h0000;
        @(negedge clk);
        b_we = 0;
    endtask

    task automatic b_read(input logic [5:0] adr, output logic [3:0] d);
        b_re = 1; b_raddr = adr;
        @(negedge clk);
        b_re = 0;
        if (OUTREG) @(negedge clk);
        d = b_rdata;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (a_busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] d;
        logic [3:0]  bd;
        logic        v;
        int          n;

        a_idle();
        b_clear_req = 0; b_we = 0; b_re = 0; b_waddr = 0; b_raddr = 0; b_wdata = 0; b_wmask = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   32'(a_busy),   32'd1);
        chk("reset_rvalid", 32'(a_rvalid), 32'd0);
        chk("reset_rdata",  32'(a_rdata),  32'd0);

        // Power-on clear: 256 busy cycles, then every word reads 0.
        resetn = 1;
        count_busy(n);
        chk("clear_len_reset", 32'(n), 32'd256);
        for (int i = 0; i < 256; i++) begin
            a_read(8'(i), d, v);
            chk("read_after_clear", 32'(d), 32'd0);
        end
        chk("rvalid_after_read", 32'(v), 32'd1);

        // Plain write then read.
        a_write(8'h10, 16'hA5A5, 16'h0000);
        a_read(8'h10, d, v);
        chk("wr_rd_0x10", 32'(d), 32'h0000_A5A5);
        chk("wr_rd_rvalid", 32'(v), 32'd1);

        // Masked write: high byte kept.
        a_write(8'h11, 16'hFFFF, 16'h0000);
        a_write(8'h11, 16'h1234, 16'hFF00);
        a_read(8'h11, d, v);
        chk("masked_write", 32'(d), 32'h0000_FF34);

        // Same-word collision is write-first; different words independent.
        a_wr_rd(8'h20, 16'hBEEF, 16'h0000, 8'h20, d);
        chk("collision_bypass", 32'(d), 32'h0000_BEEF);
        a_wr_rd(8'h20, 16'h0000, 16'h00FF, 8'h20, d);
        chk("collision_masked", 32'(d), 32'h0000_00EF);
        a_wr_rd(8'h21, 16'h7777, 16'h0000, 8'h10, d);
        chk("diff_word_read", 32'(d), 32'h0000_A5A5);
        a_read(8'h21, d, v);
        chk("diff_word_write", 32'(d), 32'h0000_7777);

        // Mixed widths: 16-bit write, 4-bit lane reads, lane 0 = LSBs.
        b_read(6'd1, bd);
        chk("b_clear_lane1", 32'(bd), 32'h5);
        b_write(4'd3, 16'hDCBA);
        b_read(6'd12, bd); chk("b_lane0", 32'(bd), 32'hA);
        b_read(6'd13, bd); chk("b_lane1", 32'(bd), 32'hB);
        b_read(6'd14, bd); chk("b_lane2", 32'(bd), 32'hC);
        b_read(6'd15, bd); chk("b_lane3", 32'(bd), 32'hD);

        // Fill array, then clear on request with accesses dropped while busy.
        for (int i = 0; i < 256; i++) a_write(8'(i), 16'(i * 257) ^ 16'h3C3C, 16'h0000);
        a_read(8'h33, d, v);
        chk("fill_check", 32'(d), 32'h0000_0F0F);
        a_clear_req = 1; a_we = 1; a_waddr = 8'h05; a_wdata = 16'h1111; a_re = 1;
        @(negedge clk);
        a_idle();
        n = 0;
        while (a_busy && n < 1000) begin
            n++;
            if (n == 10) begin
                a_we = 1; a_waddr = 8'h07; a_wdata = 16'hFFFF; a_re = 1; a_clear_req = 1;
            end else begin
                a_idle();
            end
            @(negedge clk);
        end
        a_idle();
        chk("clear_len_req", 32'(n), 32'd256);
        for (int i = 0; i < 256; i++) begin
            a_read(8'(i), d, v);
            chk("read_after_req_clear", 32'(d), 32'd0);
        end

        // Reset in the middle of a clear restarts the full sequence.
        a_write(8'd200, 16'h1234, 16'h0000);
        a_write(8'd50,  16'h4321, 16'h0000);
        a_clear_req = 1;
        @(negedge clk);
        a_idle();
        repeat (99) @(negedge clk);
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        count_busy(n);
        chk("clear_len_midreset", 32'(n), 32'd256);
        a_read(8'd200, d, v);
        chk("midreset_word200", 32'(d), 32'd0);
        a_read(8'd50, d, v);
        chk("midreset_word50", 32'(d), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
